// File: rtl/phase_adjust_ctrl.sv
// Phase-adjust sequencer: accepts an offset, applies it on a DDSM strobe, waits a settle count.
// Define PHASE_RAMP_EN to split large offsets into MAX_STEP-sized chunks over successive strobes.
module phase_adjust_ctrl #(
    parameter int PW       = 12,
    parameter int SETTLE_W = 8,
    parameter int MAX_STEP = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [PW-1:0]       i_req_phase,
    input  logic [SETTLE_W-1:0] i_req_settle,
    input  logic                i_ddsm_stb,
    input  logic                i_abort,
    output logic                o_phaseadjusten,
    output logic [PW-1:0]       o_phaseadd,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_applied_cnt
);

`ifdef PHASE_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    localparam logic signed [PW:0] STEP = (PW+1)'(MAX_STEP);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STB,
        APPLY,
        SETTLE,
        DONE
    } state_t;

    state_t                state, state_next;
    logic signed [PW:0]    rem, rem_next;
    logic signed [PW:0]    rem_mag;
    logic signed [PW:0]    chunk;
    logic [SETTLE_W-1:0]   settle, settle_next;

    // Remaining offset is one bit wider so the most negative phase has a representable magnitude.
    always_comb begin
        rem_mag = rem[PW] ? -rem : rem;
        chunk   = rem;
        if (RAMP_EN && (rem_mag > STEP)) begin
            chunk = rem[PW] ? -STEP : STEP;
        end
    end

    always_comb begin
        state_next  = state;
        rem_next    = rem;
        settle_next = settle;
        unique case (state)
            IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    rem_next    = {i_req_phase[PW-1], i_req_phase};
                    settle_next = i_req_settle;
                    state_next  = (i_req_phase == '0) ? DONE : WAIT_STB;
                end
            end
            WAIT_STB: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (i_ddsm_stb) begin
                    rem_next   = rem - chunk;
                    state_next = APPLY;
                end
            end
            APPLY: begin
                // rem already holds what is left after the chunk being applied now.
                if (i_abort)
                    state_next = IDLE;
                else if (rem != '0)
                    state_next = WAIT_STB;
                else if (settle != '0)
                    state_next = SETTLE;
                else
                    state_next = DONE;
            end
            SETTLE: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (i_ddsm_stb) begin
                    settle_next = settle - 1'b1;
                    if (settle == SETTLE_W'(1))
                        state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            rem             <= '0;
            settle          <= '0;
            o_req_ready     <= 1'b1;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_phaseadjusten <= 1'b0;
            o_phaseadd      <= '0;
            o_applied_cnt   <= '0;
        end else begin
            state           <= state_next;
            rem             <= rem_next;
            settle          <= settle_next;
            o_req_ready     <= (state_next == IDLE);
            o_busy          <= (state_next != IDLE);
            o_done          <= (state_next == DONE);
            o_phaseadjusten <= (state_next == APPLY);
            o_phaseadd      <= (state_next == APPLY) ? chunk[PW-1:0] : '0;
            if ((state_next == APPLY) && (o_applied_cnt != 16'hFFFF))
                o_applied_cnt <= o_applied_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_phase_adjust_ctrl.sv
// Bench for phase_adjust_ctrl: strobe-timeline reference model plus directed abort/reset scenarios.
module tb_phase_adjust_ctrl;

    localparam int PW       = 12;
    localparam int SETTLE_W = 8;
    localparam int MAX_STEP = 64;
    localparam int N        = 1024;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [PW-1:0]       req_phase;
    logic [SETTLE_W-1:0] req_settle;
    logic                ddsm_stb;
    logic                abort;
    logic                phaseadjusten;
    logic [PW-1:0]       phaseadd;
    logic                busy;
    logic                done;
    logic [15:0]         applied_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    phase_adjust_ctrl #(.PW(PW), .SETTLE_W(SETTLE_W), .MAX_STEP(MAX_STEP)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_phase     (req_phase),
        .i_req_settle    (req_settle),
        .i_ddsm_stb      (ddsm_stb),
        .i_abort         (abort),
        .o_phaseadjusten (phaseadjusten),
        .o_phaseadd      (phaseadd),
        .o_busy          (busy),
        .o_done          (done),
        .o_applied_cnt   (applied_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed amount applied by one enable, given what is still owed.
    function automatic int chunk_of(input int r);
`ifdef PHASE_RAMP_EN
        if (r > MAX_STEP)  return MAX_STEP;
        if (r < -MAX_STEP) return -MAX_STEP;
`endif
        return r;
    endfunction

    // One request against a periodic strobe train; timing predicted from the strobe list.
    task automatic run_txn(input int phase, input int settle, input int per, input int off);
        bit            stbv[N];
        int            exp_c[$];
        logic [PW-1:0] exp_v[$];
        int            obs_c[$];
        logic [PW-1:0] obs_v[$];
        int            done_c[$];
        int            exp_done, r, t, s, k, ch, last_e, waited;
        bit            bad_add, ready_early, ready_end;
        logic [PW-1:0] ph;

        ph = phase[PW-1:0];
        waited = 0;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end

        for (int c = 0; c < N; c++) stbv[c] = (((c + off) % per) == 0);

        // Cycle 0 is the accept cycle; its strobe is never usable.
        if (phase == 0) begin
            exp_done = 1;
        end else begin
            r = phase;
            t = 1;
            last_e = 0;
            while (r != 0) begin
                ch = chunk_of(r);
                s = t;
                while (s < N - 4 && !stbv[s]) s++;
                exp_c.push_back(s + 1);
                exp_v.push_back(ch[PW-1:0]);
                last_e = s + 1;
                t = s + 2;
                r = r - ch;
            end
            if (settle == 0) begin
                exp_done = last_e + 1;
            end else begin
                k = 0;
                s = last_e + 1;
                while (s < N - 4) begin
                    if (stbv[s]) begin
                        k++;
                        if (k == settle) break;
                    end
                    s++;
                end
                exp_done = s + 1;
            end
        end

        bad_add = 1'b0;
        ready_early = 1'b0;
        ready_end = 1'b0;
        for (int c = 0; c <= exp_done; c++) begin
            req_valid  = (c == 0);
            req_phase  = ph;
            req_settle = settle[SETTLE_W-1:0];
            ddsm_stb   = stbv[c];
            abort      = 1'b0;
            tick();
            if (phaseadjusten) begin
                obs_c.push_back(c + 1);
                obs_v.push_back(phaseadd);
            end else if (phaseadd != '0) begin
                bad_add = 1'b1;
            end
            if (done) done_c.push_back(c + 1);
            if (c + 1 <= exp_done && req_ready) ready_early = 1'b1;
            if (c + 1 == exp_done + 1) ready_end = req_ready;
        end
        req_valid = 1'b0;
        ddsm_stb  = 1'b0;

        checks++;
        if (obs_c.size() != exp_c.size()) begin
            errors++;
            $display("FAIL enable_count: got %0d enables, required %0d", obs_c.size(), exp_c.size());
        end
        for (int i = 0; i < obs_c.size() && i < exp_c.size(); i++) begin
            checks++;
            if (obs_c[i] !== exp_c[i] || obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL enable_%0d: got cycle %0d add 0x%03h, required cycle %0d add 0x%03h",
                         i, obs_c[i], obs_v[i], exp_c[i], exp_v[i]);
            end
        end
        checks++;
        if (done_c.size() != 1 || done_c[0] != exp_done) begin
            errors++;
            $display("FAIL done_timing: got %0d pulses (first cycle %0d), required one at cycle %0d",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, exp_done);
        end
        checks++;
        if (ready_early || !ready_end) begin
            errors++;
            $display("FAIL ready_timing: early=%0b ready_after_done=%0b, required 0/1", ready_early, ready_end);
        end
        checks++;
        if (bad_add) begin
            errors++;
            $display("FAIL phaseadd_idle: nonzero phaseadd without enable, required 0");
        end
        exp_cnt += exp_c.size();
        checks++;
        if (applied_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL applied_cnt: got %0d, required %0d", applied_cnt, exp_cnt);
        end
        $display("txn phase=0x%03h settle=%0d per=%0d enables=%0d done@%0d cnt=%0d",
                 ph, settle, per, obs_c.size(), exp_done, applied_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_phase = '0;
        req_settle = '0;
        ddsm_stb = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || phaseadjusten !== 1'b0 ||
            phaseadd !== '0 || applied_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: ready=%b busy=%b done=%b en=%b add=0x%03h cnt=%0d, required 1/0/0/0/0/0",
                     req_ready, busy, done, phaseadjusten, phaseadd, applied_cnt);
        end
        rst_n = 1'b1;
        tick();
        exp_cnt = 0;
        $display("reset checked");
    endtask

    task automatic test_plan();
        run_txn(12'h123, 2, 4, 1);
        run_txn(0, 5, 4, 0);
        run_txn(12'h010, 0, 4, 3);
        run_txn(-150, 1, 4, 2);
    endtask

    task automatic test_back_to_back();
        run_txn(12'h7FF, 1, 3, 0);
        run_txn(-2048, 0, 2, 1);
        run_txn(12'h001, 3, 5, 4);
    endtask

    task automatic test_abort_wait();
        bit bad;
        req_valid = 1'b1; req_phase = 12'h055; req_settle = 8'd3; ddsm_stb = 1'b0;
        tick();
        req_valid = 1'b0; abort = 1'b1; ddsm_stb = 1'b1;
        tick();
        abort = 1'b0; ddsm_stb = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || phaseadjusten !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_idle: ready=%b busy=%b en=%b done=%b, required 1/0/0/0",
                     req_ready, busy, phaseadjusten, done);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ddsm_stb = i[0];
            tick();
            if (phaseadjusten || done) bad = 1'b1;
        end
        ddsm_stb = 1'b0;
        checks++;
        if (bad || applied_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL abort_wait_after: stray=%0b cnt=%0d, required 0 and %0d", bad, applied_cnt, exp_cnt);
        end
        $display("abort in WAIT_STB with strobe checked");
    endtask

    task automatic test_abort_settle();
        bit bad;
        req_valid = 1'b1; req_phase = 12'h020; req_settle = 8'd3; ddsm_stb = 1'b0;
        tick();
        req_valid = 1'b0; ddsm_stb = 1'b1;
        tick();
        exp_cnt++;
        checks++;
        if (phaseadjusten !== 1'b1 || phaseadd !== 12'h020) begin
            errors++;
            $display("FAIL abort_settle_enable: en=%b add=0x%03h, required 1 0x020", phaseadjusten, phaseadd);
        end
        ddsm_stb = 1'b0;
        tick();
        abort = 1'b1; ddsm_stb = 1'b1;
        tick();
        abort = 1'b0; ddsm_stb = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_settle_idle: ready=%b busy=%b done=%b, required 1/0/0", req_ready, busy, done);
        end
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ddsm_stb = i[0];
            tick();
            if (phaseadjusten || done) bad = 1'b1;
        end
        ddsm_stb = 1'b0;
        checks++;
        if (bad || applied_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL abort_settle_after: stray=%0b cnt=%0d, required 0 and %0d", bad, applied_cnt, exp_cnt);
        end
        $display("abort in SETTLE checked");
    endtask

    task automatic test_random();
        int ph, st, per;
        for (int n = 0; n < 14; n++) begin
            ph  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 4095)) - 2048;
            st  = $urandom_range(0, 5);
            per = $urandom_range(2, 6);
            run_txn(ph, st, per, $urandom_range(0, per - 1));
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        req_valid = 1'b1; req_phase = 12'h030; req_settle = 8'd4; ddsm_stb = 1'b0;
        tick();
        req_valid = 1'b0; ddsm_stb = 1'b1;
        tick();
        ddsm_stb = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || phaseadjusten !== 1'b0 ||
            phaseadd !== '0 || applied_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b busy=%b done=%b en=%b add=0x%03h cnt=%0d, required 1/0/0/0/0/0",
                     req_ready, busy, done, phaseadjusten, phaseadd, applied_cnt);
        end
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ddsm_stb = i[0];
            tick();
            if (phaseadjusten || done || !req_ready) bad = 1'b1;
        end
        ddsm_stb = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_mid_after: activity after release, required idle");
        end
        $display("reset during SETTLE checked");
    endtask

    initial begin
        test_reset();
        test_plan();
        test_back_to_back();
        test_abort_wait();
        test_abort_settle();
        test_random();
        test_reset_mid();
        run_txn(12'h0F0, 2, 3, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
